// File: rtl/vc_fifo_pkg.sv
// Shared constants, width helper and per-VC status type for the virtual-channel FIFO bank.
package vc_fifo_pkg;

    localparam int DEF_DATA_W = 10;
    localparam int DEF_NUM_VC = 4;
    localparam int DEF_DEPTH  = 8;

    // Never returns 0, so a 2-entry space still gets a 1-bit select.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } vc_status_t;

endpackage

// File: rtl/vc_fifo_ram.sv
// Simple dual-port RAM shared by all VCs: synchronous write, registered read, no reset.
module vc_fifo_ram #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write in one process: a same-address access returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/vc_fifo_bank.sv
// NUM_VC independent FIFOs carved out of one shared RAM, with per-VC pointers,
// occupancy counters, status/threshold flags and sticky error bits.
module vc_fifo_bank
    import vc_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_VC = DEF_NUM_VC,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int VC_W   = safe_clog2(NUM_VC),
    parameter int ADDR_W = safe_clog2(DEPTH),
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic [VC_W-1:0]   push_vc,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    input  logic [VC_W-1:0]   pop_vc,
    input  logic [CNT_W-1:0]  af_thresh,
    input  logic [CNT_W-1:0]  ae_thresh,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] empty,
    output logic [NUM_VC-1:0] almost_full,
    output logic [NUM_VC-1:0] almost_empty,
    output logic [NUM_VC-1:0] overflow_err,
    output logic [NUM_VC-1:0] underflow_err
);

    localparam int RAM_AW    = VC_W + ADDR_W;
    localparam int RAM_DEPTH = NUM_VC * DEPTH;

    logic [ADDR_W-1:0] wr_ptr_reg [NUM_VC];
    logic [ADDR_W-1:0] rd_ptr_reg [NUM_VC];
    logic [CNT_W-1:0]  count_reg  [NUM_VC];
    vc_status_t        status     [NUM_VC];

    logic [NUM_VC-1:0] push_hit;
    logic [NUM_VC-1:0] pop_hit;
    logic [NUM_VC-1:0] push_acc;
    logic [NUM_VC-1:0] pop_acc;
    logic [NUM_VC-1:0] overflow_reg;
    logic [NUM_VC-1:0] underflow_reg;
    logic              valid_reg;
    logic              loaded_reg;

    logic              push_vc_ok;
    logic              pop_vc_ok;
    logic [ADDR_W-1:0] wr_ptr_sel;
    logic [ADDR_W-1:0] rd_ptr_sel;
    logic [DATA_W-1:0] ram_q;

    // Only a non-power-of-two bank can see VC selects past the last channel.
    generate
        if ((1 << VC_W) == NUM_VC) begin : g_vc_pow2
            assign push_vc_ok = 1'b1;
            assign pop_vc_ok  = 1'b1;
        end else begin : g_vc_npow2
            localparam logic [VC_W:0] NUM_VC_X = NUM_VC[VC_W:0];
            assign push_vc_ok = ({1'b0, push_vc} < NUM_VC_X);
            assign pop_vc_ok  = ({1'b0, pop_vc} < NUM_VC_X);
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            assign push_hit[gi] = push && push_vc_ok && (push_vc == VC_W'(gi));
            assign pop_hit[gi]  = pop  && pop_vc_ok  && (pop_vc  == VC_W'(gi));

            assign status[gi] = '{
                full:         (count_reg[gi] == CNT_W'(DEPTH)),
                empty:        (count_reg[gi] == '0),
                almost_full:  (count_reg[gi] >= af_thresh),
                almost_empty: (count_reg[gi] <= ae_thresh)
            };

            // A full VC still takes a push when the same cycle pops it;
            // an empty VC never pops, even with a same-cycle push.
            assign pop_acc[gi]  = pop_hit[gi] && !status[gi].empty;
            assign push_acc[gi] = push_hit[gi] && (!status[gi].full || pop_acc[gi]);

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    wr_ptr_reg[gi] <= '0;
                    rd_ptr_reg[gi] <= '0;
                    count_reg[gi]  <= '0;
                end else begin
                    if (push_acc[gi]) begin
                        wr_ptr_reg[gi] <= wr_ptr_reg[gi] + 1'b1;
                    end
                    if (pop_acc[gi]) begin
                        rd_ptr_reg[gi] <= rd_ptr_reg[gi] + 1'b1;
                    end
                    case ({push_acc[gi], pop_acc[gi]})
                        2'b10:   count_reg[gi] <= count_reg[gi] + 1'b1;
                        2'b01:   count_reg[gi] <= count_reg[gi] - 1'b1;
                        default: count_reg[gi] <= count_reg[gi];
                    endcase
                end
            end

            assign full[gi]         = status[gi].full;
            assign empty[gi]        = status[gi].empty;
            assign almost_full[gi]  = status[gi].almost_full;
            assign almost_empty[gi] = status[gi].almost_empty;
        end
    endgenerate

    always_comb begin
        wr_ptr_sel = '0;
        rd_ptr_sel = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (push_hit[i]) begin
                wr_ptr_sel = wr_ptr_reg[i];
            end
            if (pop_hit[i]) begin
                rd_ptr_sel = rd_ptr_reg[i];
            end
        end
    end

    vc_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (RAM_AW),
        .DEPTH  (RAM_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (|push_acc),
        .wr_addr ({push_vc, wr_ptr_sel}),
        .wr_data (data_in),
        .rd_en   (|pop_acc),
        .rd_addr ({pop_vc, rd_ptr_sel}),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid_reg     <= 1'b0;
            loaded_reg    <= 1'b0;
            overflow_reg  <= '0;
            underflow_reg <= '0;
        end else begin
            valid_reg     <= |pop_acc;
            if (|pop_acc) begin
                loaded_reg <= 1'b1;
            end
            overflow_reg  <= overflow_reg  | (push_hit & ~push_acc);
            underflow_reg <= underflow_reg | (pop_hit  & ~pop_acc);
        end
    end

    // The RAM output has no reset, so it is masked until a pop after reset loads it.
    assign data_out      = loaded_reg ? ram_q : '0;
    assign valid_out     = valid_reg;
    assign overflow_err  = overflow_reg;
    assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Directed bench for vc_fifo_bank: hand-computed vectors per VC, plus a small queue model for interleaved traffic.
module tb_vc_fifo_bank;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       push;
    logic [1:0] push_vc;
    logic [9:0] data_in;
    logic       pop;
    logic [1:0] pop_vc;
    logic [3:0] af_thresh;
    logic [3:0] ae_thresh;
    logic [9:0] data_out;
    logic       valid_out;
    logic [3:0] full;
    logic [3:0] empty;
    logic [3:0] almost_full;
    logic [3:0] almost_empty;
    logic [3:0] overflow_err;
    logic [3:0] underflow_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] q0 [$];
    logic [9:0] q3 [$];

    vc_fifo_bank dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .push          (push),
        .push_vc       (push_vc),
        .data_in       (data_in),
        .pop           (pop),
        .pop_vc        (pop_vc),
        .af_thresh     (af_thresh),
        .ae_thresh     (ae_thresh),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .full          (full),
        .empty         (empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [1:0] vc, input logic [9:0] d);
        push = 1'b1; push_vc = vc; data_in = d;
        tick();
        push = 1'b0;
        $display("push vc=%0d data=0x%03h", vc, d);
    endtask

    task automatic do_pop_check(input string tag, input logic [1:0] vc, input logic [9:0] exp);
        pop = 1'b1; pop_vc = vc;
        tick();
        pop = 1'b0;
        $display("pop  vc=%0d data=0x%03h valid=%0b", vc, data_out, valid_out);
        check_val({tag, "_valid"}, valid_out, 1);
        check_val({tag, "_data"}, data_out, exp);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_empty"}, empty, 4'hF);
        check_val({tag, "_full"}, full, 4'h0);
        check_val({tag, "_valid"}, valid_out, 0);
        check_val({tag, "_data"}, data_out, 0);
        check_val({tag, "_ovf"}, overflow_err, 0);
        check_val({tag, "_udf"}, underflow_err, 0);
    endtask

    initial begin
        reset_L = 1'b0; push = 1'b0; pop = 1'b0;
        push_vc = '0; pop_vc = '0; data_in = '0;
        af_thresh = 4'd8; ae_thresh = 4'd0;

        // 1: reset state
        tick(); tick();
        check_idle("rst_hold");
        check_val("rst_ae", almost_empty, 4'hF);
        check_val("rst_af", almost_full, 4'h0);
        reset_L = 1'b1;
        tick();
        check_idle("rst_rel");

        // 2: fill and drain VC2
        for (int i = 1; i <= 8; i++) begin
            do_push(2'd2, 10'(i));
            check_val($sformatf("t2_full_%0d", i), full[2], (i == 8));
        end
        check_val("t2_af", almost_full, 4'b0100);
        for (int i = 1; i <= 8; i++) begin
            do_pop_check($sformatf("t2_pop%0d", i), 2'd2, 10'(i));
            tick();
            check_val($sformatf("t2_pulse%0d", i), valid_out, 0);
        end
        check_val("t2_empty", empty, 4'hF);

        // 3: overflow on VC1, then push+pop while full
        for (int i = 1; i <= 8; i++) do_push(2'd1, 10'h100 + 10'(i));
        do_push(2'd1, 10'h3FF);
        check_val("t3_ovf", overflow_err, 4'b0010);
        check_val("t3_full", full, 4'b0010);
        push = 1'b1; push_vc = 2'd1; data_in = 10'h155;
        pop = 1'b1; pop_vc = 2'd1;
        tick();
        push = 1'b0; pop = 1'b0;
        $display("push+pop vc=1 data=0x%03h", data_out);
        check_val("t3_pp_valid", valid_out, 1);
        check_val("t3_pp_data", data_out, 10'h101);
        check_val("t3_pp_full", full, 4'b0010);
        check_val("t3_pp_ovf", overflow_err, 4'b0010);
        for (int i = 2; i <= 8; i++)
            do_pop_check($sformatf("t3_drain%0d", i), 2'd1, 10'h100 + 10'(i));
        do_pop_check("t3_drain_last", 2'd1, 10'h155);
        check_val("t3_empty", empty, 4'hF);

        // 4: pop of empty VC3 with a same-cycle push
        push = 1'b1; push_vc = 2'd3; data_in = 10'h0AA;
        pop = 1'b1; pop_vc = 2'd3;
        tick();
        push = 1'b0; pop = 1'b0;
        $display("push+pop vc=3 (empty) valid=%0b", valid_out);
        check_val("t4_udf", underflow_err, 4'b1000);
        check_val("t4_valid", valid_out, 0);
        check_val("t4_hold", data_out, 10'h155);
        check_val("t4_empty", empty, 4'b0111);
        do_pop_check("t4_pop", 2'd3, 10'h0AA);
        check_val("t4_empty2", empty, 4'hF);

        // 5: thresholds on VC0
        af_thresh = 4'd6; ae_thresh = 4'd1;
        #1;
        check_val("t5_ae0", almost_empty[0], 1);
        for (int k = 1; k <= 6; k++) begin
            do_push(2'd0, 10'h010 + 10'(k - 1));
            check_val($sformatf("t5_af_p%0d", k), almost_full[0], (k >= 6));
            check_val($sformatf("t5_ae_p%0d", k), almost_empty[0], (k <= 1));
        end
        for (int j = 1; j <= 5; j++) begin
            do_pop_check($sformatf("t5_pop%0d", j), 2'd0, 10'h010 + 10'(j - 1));
            check_val($sformatf("t5_af_q%0d", j), almost_full[0], ((6 - j) >= 6));
            check_val($sformatf("t5_ae_q%0d", j), almost_empty[0], ((6 - j) <= 1));
        end
        do_pop_check("t5_pop6", 2'd0, 10'h015);

        // 6: interleaved VC0/VC3 traffic with pointer wrap, then async reset
        for (int k = 0; k < 40; k++) begin
            logic [9:0] d;
            logic       exp_v;
            logic [9:0] exp_d;
            d = 10'h200 + 10'(k);
            push = 1'b1; data_in = d;
            push_vc = (k % 2 == 1) ? 2'd3 : 2'd0;
            pop_vc  = (k % 2 == 1) ? 2'd0 : 2'd3;
            exp_v = 1'b0; exp_d = '0;
            if (pop_vc == 2'd0 && q0.size() != 0) begin exp_v = 1'b1; exp_d = q0.pop_front(); end
            if (pop_vc == 2'd3 && q3.size() != 0) begin exp_v = 1'b1; exp_d = q3.pop_front(); end
            pop = exp_v;
            if (push_vc == 2'd0) q0.push_back(d); else q3.push_back(d);
            tick();
            $display("xfer k=%0d push vc=%0d data=0x%03h pop vc=%0d valid=%0b out=0x%03h",
                     k, push_vc, d, pop_vc, valid_out, data_out);
            check_val($sformatf("t6_v%0d", k), valid_out, exp_v);
            if (exp_v) check_val($sformatf("t6_d%0d", k), data_out, exp_d);
        end
        push = 1'b1; push_vc = 2'd0; data_in = 10'h2FF;
        pop = 1'b1; pop_vc = 2'd3;
        tick();
        push = 1'b0; pop = 1'b0;
        check_val("t6_last_v", valid_out, 1);
        check_val("t6_last_d", data_out, 10'h227);
        check_val("t6_pre_empty", empty, 4'b1110);
        #2;
        reset_L = 1'b0;
        #1;
        check_idle("t6_async");
        check_val("t6_async_ae", almost_empty, 4'hF);
        tick();
        reset_L = 1'b1;
        tick();
        check_idle("t6_post");
        do_push(2'd0, 10'h3A5);
        do_pop_check("t6_after", 2'd0, 10'h3A5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
